md_issue_ctrl: RTL and testbench
================================

Name: md_issue_ctrl

Overview:
- E-stage issue and hazard controller that sits directly upstream of the MultDiv unit.
- Turns E-stage mult/div/mthi/mtlo requests into the unit's start/op inputs.
- Tracks the in-flight operation with its own latency model and generates the D-stage stall for any HI/LO-class instruction.
- Flags protocol errors and model/unit disagreement; counts stall cycles for performance reporting.

Parameters:
MUL_LAT, 5, cycles after the start cycle during which a mult/multu keeps the unit busy
DIV_LAT, 10, cycles after the start cycle during which a div/divu keeps the unit busy
CNT_W, 4, width of the internal countdown; must hold max(MUL_LAT,DIV_LAT)-1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
e_valid  in  1  E-stage instruction is valid
e_flush  in  1  E-stage instruction is being killed this cycle
e_md_op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 7 none
d_md_use  in  1  D-stage instruction is mult/div/mthi/mtlo/mfhi/mflo
md_busy  in  1  busy output of MultDiv
md_start  out  1  start pulse to MultDiv
md_op  out  3  op code to MultDiv
stall_d  out  1  freeze F/D, bubble into E
hilo_ready  out  1  predicted HI/LO hold final results
err  out  2  sticky: [0] model/unit busy mismatch, [1] issue while busy
stall_cnt  out  32  saturating count of stall_d cycles

Behaviour:
- FSM states: IDLE, MUL, DIV. Countdown cnt[CNT_W-1:0]. Held register op_q[2:0].
- Reset values: state=IDLE, cnt=0, op_q=0, err=0, stall_cnt=0. Hence md_start=0, md_op=0, stall_d=0, hilo_ready=1.
- issue = e_valid & ~e_flush & (e_md_op<4) & (state==IDLE). md_start = issue (combinational, same cycle).
- md_op rules:
  - e_md_op when issue is true.
  - e_md_op when (e_md_op is 4/5) & e_valid & ~e_flush & state==IDLE.
  - op_q otherwise.
  - Never drive 6/7 to the unit: 6/7 aborts a running operation.
- On issue: op_q<=e_md_op; state<=MUL for op 0/1, DIV for op 2/3; cnt<=LAT-1.
- In MUL/DIV:
  - cnt!=0 -> cnt<=cnt-1.
  - cnt==0 -> state<=IDLE.
  - So the non-IDLE state lasts exactly LAT cycles after the start cycle.
- busy_pred = md_start | (state!=IDLE).
- stall_d = d_md_use & busy_pred. A D-stage md instruction stalls in the start cycle and through all LAT following cycles. It proceeds in the first cycle after the unit has written HI/LO.
- hilo_ready = ~busy_pred.
- Illegal E request while state!=IDLE (e_valid & ~e_flush & e_md_op<=5):
  - md_start stays 0 and md_op stays op_q; no corruption of the running op.
  - err[1]<=1.
- e_flush=1 suppresses issue and mthi/mtlo regardless of e_valid.
- Cross-check: each cycle with state!=IDLE or md_start, busy_pred!=md_busy sets err[0]. Errors stay set until reset.
- stall_cnt increments on every cycle with stall_d=1 and saturates at 0xFFFFFFFF.
- Reset asserted mid-operation: FSM returns to IDLE immediately (asynchronous). MultDiv is reset in the same cycle, so no stale busy remains.
- Back-to-back issue is allowed: an op may start in the first IDLE cycle after the previous op completes.

Decomposition:
- Shared package holds:
  - MD_OP_* constants: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, NONE=7.
  - FSM state encoding.
  - Default MUL_LAT/DIV_LAT, reused by MultDiv and the hazard bench.
- One sub-module: sat_counter32 (enable, async active-low reset, saturating), instantiated for stall_cnt.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release -> md_start=0, md_op=0, stall_d=0, hilo_ready=1, err=0, stall_cnt=0.
- e_valid=1, e_md_op=0 at cycle t; d_md_use=1 from t -> md_start=1 only at t; stall_d=1 for cycles t..t+5; hilo_ready=1 at t+6; stall_cnt=6; err=0.
- divu at t, then mflo in D -> stall_d=1 for t..t+10 (11 cycles); md_op=3 held throughout; no state change caused by op 7.
- Flush: e_valid=1, e_flush=1, e_md_op=2 -> md_start=0, state stays IDLE, stall_d=0 even with d_md_use=1.
- Protocol error: mult at t, forced e_md_op=4 with e_valid=1 at t+2 -> md_op stays 0, no start, err[1]=1 and sticky. Then mthi in IDLE at t+7 -> md_op=4 for one cycle.
- Model mismatch: MultDiv stub holds md_busy low during MUL -> err[0]=1 from t+1 and stays set. Mid-MUL reset=0 -> state IDLE, err cleared, stall_d=0.

Source files
------------

// File: rtl/md_issue_ctrl_pkg.sv
// Shared definitions for the MultDiv issue/hazard controller: op codes,
// FSM encoding, default latencies and small op-decode helpers.
package md_issue_ctrl_pkg;

  // E-stage MultDiv op codes
  localparam logic [2:0] MD_OP_MULT  = 3'd0;
  localparam logic [2:0] MD_OP_MULTU = 3'd1;
  localparam logic [2:0] MD_OP_DIV   = 3'd2;
  localparam logic [2:0] MD_OP_DIVU  = 3'd3;
  localparam logic [2:0] MD_OP_MTHI  = 3'd4;
  localparam logic [2:0] MD_OP_MTLO  = 3'd5;
  localparam logic [2:0] MD_OP_NONE  = 3'd7;

  // Busy cycles following the start cycle; shared with the MultDiv unit model
  localparam int unsigned MD_MUL_LAT = 5;
  localparam int unsigned MD_DIV_LAT = 10;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2
  } md_state_e;

  // mult/multu/div/divu: ops that occupy the unit for several cycles
  function automatic logic md_op_is_arith(input logic [2:0] op);
    return op < MD_OP_MTHI;
  endfunction

  // mthi/mtlo: single-cycle writes of HI or LO
  function automatic logic md_op_is_mt(input logic [2:0] op);
    return (op == MD_OP_MTHI) || (op == MD_OP_MTLO);
  endfunction

  function automatic logic md_op_is_div(input logic [2:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

endpackage

// File: rtl/md_issue_ctrl_sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter32 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_d, cnt_q;

  // Increment on enable unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage issue and hazard control in front of the MultDiv unit. Issues
// mult/div/mthi/mtlo, predicts unit occupancy with a local latency model,
// stalls D-stage HI/LO users, flags protocol and model errors, and counts
// stall cycles.
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = MD_MUL_LAT,
  parameter int unsigned DIV_LAT = MD_DIV_LAT,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic        e_flush,
  input  logic [2:0]  e_md_op,
  input  logic        d_md_use,
  input  logic        md_busy,
  output logic        md_start,
  output logic [2:0]  md_op,
  output logic        stall_d,
  output logic        hilo_ready,
  output logic [1:0]  err,
  output logic [31:0] stall_cnt
);

  localparam logic [CNT_W-1:0] MulCntInit = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DivCntInit = CNT_W'(DIV_LAT - 1);

  md_state_e        state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [2:0]       op_d, op_q;
  logic [1:0]       err_d, err_q;

  logic e_req;      // live, unflushed E-stage instruction
  logic idle;
  logic issue;      // multi-cycle op accepted this cycle
  logic mt_write;   // mthi/mtlo passed through this cycle
  logic illegal;    // md request while the unit is still occupied
  logic busy_pred;

  // Request decode and hazard outputs
  always_comb begin
    e_req      = e_valid & ~e_flush;
    idle       = (state_q == StIdle);
    issue      = e_req & md_op_is_arith(e_md_op) & idle;
    mt_write   = e_req & md_op_is_mt(e_md_op) & idle;
    illegal    = e_req & (e_md_op <= MD_OP_MTLO) & ~idle;
    busy_pred  = issue | ~idle;

    md_start   = issue;
    // Only legal ops ever reach the unit; everything else replays the held op
    md_op      = (issue | mt_write) ? e_md_op : op_q;
    stall_d    = d_md_use & busy_pred;
    hilo_ready = ~busy_pred;
    err        = err_q;
  end

  // Occupancy FSM, held op and sticky error next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (issue) begin
          op_d = e_md_op;
          if (md_op_is_div(e_md_op)) begin
            state_d = StDiv;
            cnt_d   = DivCntInit;
          end else begin
            state_d = StMul;
            cnt_d   = MulCntInit;
          end
        end
      end
      StMul, StDiv: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    if (illegal) begin
      err_d[1] = 1'b1;
    end
    // Only meaningful while the model expects the unit to be working
    if (busy_pred && (busy_pred != md_busy)) begin
      err_d[0] = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= 3'd0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  sat_counter32 u_stall_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (stall_d),
    .cnt_o  (stall_cnt)
  );

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: directed scenarios then random traffic, all
// compared against a cycle-level occupancy model ("busy for N more cycles").
module tb_md_issue_ctrl;

  localparam int MulLat = 5;
  localparam int DivLat = 10;

  logic        clk;
  logic        reset;
  logic        e_valid;
  logic        e_flush;
  logic [2:0]  e_md_op;
  logic        d_md_use;
  logic        md_busy;
  logic        md_start;
  logic [2:0]  md_op;
  logic        stall_d;
  logic        hilo_ready;
  logic [1:0]  err;
  logic [31:0] stall_cnt;

  md_issue_ctrl #(
    .MUL_LAT (MulLat),
    .DIV_LAT (DivLat),
    .CNT_W   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .e_valid    (e_valid),
    .e_flush    (e_flush),
    .e_md_op    (e_md_op),
    .d_md_use   (d_md_use),
    .md_busy    (md_busy),
    .md_start   (md_start),
    .md_op      (md_op),
    .stall_d    (stall_d),
    .hilo_ready (hilo_ready),
    .err        (err),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state
  int          m_rem;    // busy cycles still to come after the current one
  logic [2:0]  m_op;     // last op actually started
  logic [1:0]  m_err;
  longint      m_stall;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rem   = 0;
    m_op    = 3'd0;
    m_err   = 2'b00;
    m_stall = 0;
  endtask

  // One clock cycle: drive inputs, check against the model, advance the model.
  // busy_lie makes the MultDiv stub report idle while it should be working.
  task automatic cycle(input logic v, input logic f, input logic [2:0] op,
                       input logic du, input logic busy_lie);
    logic idle, iss, mt, bp, stall, busy_in;
    logic [2:0] exp_op;
    @(negedge clk);
    idle   = (m_rem == 0);
    iss    = v && !f && (op <= 3) && idle;
    mt     = v && !f && (op == 4 || op == 5) && idle;
    bp     = iss || !idle;
    stall  = du && bp;
    exp_op = (iss || mt) ? op : m_op;
    busy_in = busy_lie ? 1'b0 : bp;
    e_valid  = v;
    e_flush  = f;
    e_md_op  = op;
    d_md_use = du;
    md_busy  = busy_in;
    #1;
    check_eq("md_start",   {31'd0, md_start},   {31'd0, iss});
    check_eq("md_op",      {29'd0, md_op},      {29'd0, exp_op});
    check_eq("stall_d",    {31'd0, stall_d},    {31'd0, stall});
    check_eq("hilo_ready", {31'd0, hilo_ready}, {31'd0, !bp});
    check_eq("err",        {30'd0, err},        {30'd0, m_err});
    check_eq("stall_cnt",  stall_cnt,           m_stall[31:0]);
    // Effects of this cycle, visible from the next one
    if (v && !f && op <= 5 && !idle) m_err[1] = 1'b1;
    if (bp && !busy_in) m_err[0] = 1'b1;
    if (stall && m_stall < 64'h0000_0000_FFFF_FFFF) m_stall++;
    if (iss) begin
      m_rem = (op >= 2) ? DivLat : MulLat;
      m_op  = op;
    end else if (m_rem > 0) begin
      m_rem--;
    end
  endtask

  // Asynchronous reset, asserted mid-cycle; D-stage user held to expose stalls
  task automatic do_reset(input int n);
    @(negedge clk);
    e_valid  = 1'b0;
    e_flush  = 1'b0;
    e_md_op  = 3'd7;
    d_md_use = 1'b1;
    md_busy  = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_eq("rst_stall_d",   {31'd0, stall_d},    32'd0);
    check_eq("rst_hilo",      {31'd0, hilo_ready}, 32'd1);
    check_eq("rst_err",       {30'd0, err},        32'd0);
    check_eq("rst_stall_cnt", stall_cnt,           32'd0);
    check_eq("rst_md_start",  {31'd0, md_start},   32'd0);
    check_eq("rst_md_op",     {29'd0, md_op},      32'd0);
    repeat (n) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    e_valid  = 1'b0;
    e_flush  = 1'b0;
    e_md_op  = 3'd7;
    d_md_use = 1'b0;
    md_busy  = 1'b0;
    model_reset();

    do_reset(3);
    cycle(0, 0, 3'd7, 0, 0);

    // mult with a dependent D-stage user: 6 stall cycles
    cycle(1, 0, 3'd0, 1, 0);
    repeat (MulLat) cycle(0, 0, 3'd7, 1, 0);
    cycle(0, 0, 3'd7, 1, 0);
    check_eq("mult_stall_total", stall_cnt, 32'd6);

    // divu then mflo; op 7 in E while busy must not disturb anything
    cycle(1, 0, 3'd3, 1, 0);
    repeat (DivLat) cycle(1, 0, 3'd7, 1, 0);
    cycle(0, 0, 3'd7, 1, 0);

    // Flushed div never starts
    repeat (3) cycle(1, 1, 3'd2, 1, 0);
    cycle(0, 0, 3'd7, 1, 0);

    // Protocol error: mthi while mult runs, then legal mthi once idle
    cycle(1, 0, 3'd0, 0, 0);
    cycle(0, 0, 3'd7, 0, 0);
    cycle(1, 0, 3'd4, 0, 0);
    repeat (4) cycle(0, 0, 3'd7, 0, 0);
    cycle(1, 0, 3'd4, 0, 0);
    cycle(0, 0, 3'd7, 0, 0);
    check_eq("err1_sticky", {30'd0, err}, 32'd2);

    // Back-to-back issue in the first idle cycle
    cycle(1, 0, 3'd1, 1, 0);
    repeat (MulLat) cycle(0, 0, 3'd7, 1, 0);
    cycle(1, 0, 3'd2, 1, 0);
    repeat (DivLat) cycle(0, 0, 3'd7, 1, 0);

    // Model mismatch: stub claims idle during a mult, then reset mid-op
    do_reset(1);
    cycle(1, 0, 3'd0, 1, 1);
    repeat (3) cycle(0, 0, 3'd7, 1, 1);
    check_eq("err0_set", {31'd0, err[0]}, 32'd1);
    do_reset(2);
    cycle(0, 0, 3'd7, 1, 0);

    // Random traffic with occasional resets
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        cycle(($urandom_range(0, 9) < 6),
              ($urandom_range(0, 9) == 0),
              3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 199) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
